// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: pipeline writeback, aux result and register-file write bundle
interface rf_wb_arbiter_if #(parameter int DEPTH = 2);
   localparam int CW = $clog2(DEPTH + 1);
   logic          wb_we;
   logic [4:0]    wb_addr;
   logic [31:0]   wb_data;
   logic          pipe_stall;
   logic          aux_valid;
   logic          aux_ready;
   logic [4:0]    aux_addr;
   logic [31:0]   aux_data;
   logic          rf_we;
   logic [4:0]    rf_addr;
   logic [31:0]   rf_data;
   logic [CW-1:0] buf_count;
   modport master (
      output wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
      input  pipe_stall, aux_ready, rf_we, rf_addr, rf_data, buf_count
   );
   modport slave (
      input  wb_we, wb_addr, wb_data, aux_valid, aux_addr, aux_data,
      output pipe_stall, aux_ready, rf_we, rf_addr, rf_data, buf_count
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between pipeline writeback and a buffered aux source
module rf_wb_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 3
) (
   input logic             clk,
   input logic             rst,
   rf_wb_arbiter_if.slave  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(MAX_WAIT + 2);
   logic [4:0]    addr_q [DEPTH];
   logic [4:0]    addr_d [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          rf_we_q, rf_we_d;
   logic [4:0]    rf_addr_q, rf_addr_d;
   logic [31:0]   rf_data_q, rf_data_d;
   logic          p, a, aux_gnt, pipe_gnt, push;
   logic [DEPTH-1:0] keep;

   always_comb begin
      p        = bus.wb_we && bus.wb_addr != 5'd0;
      a        = count_q != '0;
      aux_gnt  = a && (!p || count_q == CW'(DEPTH) || wait_q == WW'(MAX_WAIT));
      pipe_gnt = p && !aux_gnt;
      push     = bus.aux_valid && bus.aux_ready && bus.aux_addr != 5'd0 &&
                 !(pipe_gnt && bus.aux_addr == bus.wb_addr);
      rf_we_d   = aux_gnt || pipe_gnt;
      rf_addr_d = aux_gnt ? addr_q[0] : pipe_gnt ? bus.wb_addr : rf_addr_q;
      rf_data_d = aux_gnt ? data_q[0] : pipe_gnt ? bus.wb_data : rf_data_q;
   end

   // Survivors (not popped, not superseded) are compacted to the front, then the push appends.
   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      keep    = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++)
         keep[i] = i < int'(count_q) && !(aux_gnt && i == 0) &&
                   !(pipe_gnt && addr_q[i] == bus.wb_addr);
      for (int i = 0; i < DEPTH; i++)
         if (keep[i]) begin
            for (int k = 0; k < DEPTH; k++)
               if (k == int'(count_d)) begin
                  addr_d[k] = addr_q[i];
                  data_d[k] = data_q[i];
               end
            count_d = count_d + 1'b1;
         end
      for (int k = 0; k < DEPTH; k++)
         if (push && k == int'(count_d)) begin
            addr_d[k] = bus.aux_addr;
            data_d[k] = bus.aux_data;
         end
      count_d = count_d + CW'(push);
      wait_d  = (!a || aux_gnt || !keep[0]) ? '0 :
                (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         wait_q    <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         count_q   <= count_d;
         wait_q    <= wait_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

   assign bus.pipe_stall = !rst && p && aux_gnt;
   assign bus.aux_ready  = !rst && count_q < CW'(DEPTH);
   assign bus.rf_we      = rf_we_q;
   assign bus.rf_addr    = rf_addr_q;
   assign bus.rf_data    = rf_data_q;
   assign bus.buf_count  = count_q;
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (output of the MEM/WB stage register) and an auxiliary long-latency result source (multi-cycle mul/div unit). Aux results are held in a small in-order buffer. Pipeline writes win by default; the aux side wins when its buffer is full or its head has waited too long, and in that case the block stalls the pipeline. Output is a registered write port that drives the register file directly.

## Interface

Reset is `rst`, synchronous, active-high. Clock is `clk`.

**Parameters**
- `DEPTH`, default 2: aux buffer entries, range 2..4.
- `MAX_WAIT`, default 3: cycles a buffered aux head may be bypassed before it is forced through.

**Ports** (name, direction, width, meaning)
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `wb_we` in 1: pipeline writeback enable, from MEM/WB.
- `wb_addr` in 5: pipeline destination register.
- `wb_data` in 32: pipeline write data.
- `pipe_stall` out 1: combinational; pipeline must hold MEM/WB and earlier stages this cycle.
- `aux_valid` in 1: aux result valid.
- `aux_ready` out 1: aux buffer can accept; depends only on registered state.
- `aux_addr` in 5: aux destination register.
- `aux_data` in 32: aux result.
- `rf_we` out 1: registered register-file write enable.
- `rf_addr` out 5: registered register-file write address.
- `rf_data` out 32: registered register-file write data.
- `buf_count` out clog2(DEPTH+1): aux buffer occupancy.

## Operation

**Request definitions**
- P = `wb_we` && `wb_addr` != 0. A pipeline write to x0 is not a request and is never written.
- A = `buf_count` != 0.

**Grant rule, evaluated every cycle**
- If A && (!P || `buf_count` == DEPTH || `wait_cnt` == MAX_WAIT), the aux side is granted:
  - pop the head;
  - `pipe_stall` = P.
- Else if P, the pipeline is granted. `pipe_stall` = 0.
- Else there is no write.

**Stall handling**
- A stalled pipeline presents the same `wb_*` values the next cycle.
- The block does not latch pipeline data.

**Wait counter** (`wait_cnt`, internal)
- Cleared on pop, and while the buffer is empty.
- Otherwise increments each cycle the head is present but not granted.
- Saturates at MAX_WAIT.

**Push**
- Occurs when `aux_valid` && `aux_ready`.
- `aux_ready` = (`buf_count` < DEPTH) && !`rst`.
- An aux entry with `aux_addr` == 0 is handshaked but not stored.
- No bypass: a pushed entry is granted no earlier than the next cycle.
- Push and pop may occur in the same cycle, with count net 0.

**Supersede rule** (the issue logic guarantees the pipeline instruction is younger)
- When the pipeline is granted a write to x, every buffered entry with addr x is removed.
- A same-cycle incoming aux entry with addr x is also dropped.
- Remaining entries keep their order, and `buf_count` decreases accordingly.
- A stalled pipeline write kills nothing.

**Output registers**
- The granted address and data are loaded into `rf_*` with `rf_we` = 1.
- With no grant, `rf_we` = 0; `rf_addr` and `rf_data` hold their previous values.

**Reset**
- Resets `rf_we`, `rf_addr`, `rf_data` to 0.
- Empties the buffer; `buf_count` = 0 and `wait_cnt` = 0.
- `pipe_stall` = 0 and `aux_ready` = 0 while `rst` is high.
- Reset mid-operation discards buffered aux results without writing them.

## Timing

- Latency is 1 cycle from grant to `rf_we` high. The register file sees the write on the following edge.
- At most one write per cycle.
- `pipe_stall` is combinational from `wb_we`, `wb_addr` and registered state only. It has no path from `aux_*`.
- `aux_ready` is registered-state only. It has no combinational path from `aux_valid`.
- Full-buffer case: with DEPTH entries present and P continuous, the aux side is granted every cycle until the buffer is no longer full.
- Starvation bound: a buffered head is written within MAX_WAIT+1 cycles of becoming head.

## Test plan

1. **Pipeline only.** Drive `wb_we`=1, addr 5, data 0xDEADBEEF for 1 cycle with the aux side idle.
   - Next cycle: `rf_we`=1, `rf_addr`=5, `rf_data`=0xDEADBEEF, `pipe_stall`=0 throughout.
   - A write to x0 produces `rf_we`=0.
2. **Aux when pipeline idle.** Push aux addr 7, data 0x11 with `wb_we`=0.
   - `buf_count`=1 next cycle; granted that cycle.
   - `rf_we`=1, addr 7, data 0x11 one cycle later; `buf_count` returns to 0.
3. **Starvation.** Hold P high continuously to distinct addrs and push one aux entry (addr 9).
   - It is bypassed 3 cycles.
   - On the 4th cycle `pipe_stall`=1 and the aux entry is written.
   - The stalled pipeline write appears the following cycle.
4. **Full buffer.** DEPTH=2: push 2 aux entries while P is high.
   - `aux_ready`=0 at count 2.
   - The aux side is granted immediately, with `pipe_stall`=1.
   - `aux_ready` returns to 1 the cycle after the pop.
5. **Supersede.** Buffer holds addr 3 (0xAA); pipeline is granted a write of addr 3 (0xBB).
   - `rf_data`=0xBB; `buf_count` drops to 0.
   - 0xAA is never written.
   - A same-cycle aux push to addr 3 is dropped.
6. **Reset mid-operation.** Assert `rst` with 2 entries buffered.
   - All outputs are 0 and `buf_count`=0.
   - No aux write appears after reset is released.
